// File: rtl/quadrature_decoder_if.sv
// Bus bundle between a quadrature source and the decoder: encoder phases and
// clear toward the decoder, position/status back from it.
interface quadrature_decoder_if #(
  parameter int unsigned WIDTH = 4
);
  logic             a;
  logic             b;
  logic             clr;
  logic [WIDTH-1:0] out;
  logic             dir;
  logic             step;
  logic             err;
  logic             sat;

  // Source side: drives phases and clear, observes the decoded state
  modport master (
    output a, b, clr,
    input  out, dir, step, err, sat
  );

  // Decoder side
  modport slave (
    input  a, b, clr,
    output out, dir, step, err, sat
  );
endinterface

// File: rtl/quadrature_decoder.sv
// Quadrature decoder: synchronizes the A/B phases, decodes Gray-code steps
// into up/down events, keeps a saturating position and flags illegal jumps.
module quadrature_decoder #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  quadrature_decoder_if.slave bus
);

  localparam int unsigned CNT_W = 3;
  localparam logic [WIDTH-1:0] OUT_MAX = '1;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] a_sync_q, b_sync_q;
  logic [1:0]             s;
  logic [1:0]             prev_q, prev_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0]       out_q, out_d;
  logic                   dir_q, dir_d;
  logic                   step_q, step_d;
  logic                   err_q, err_d;
  logic                   ev_up, ev_dn, ev_bad;

  // Input synchronizers, one shift chain per phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sync_q <= '0;
      b_sync_q <= '0;
    end else begin
      a_sync_q <= {a_sync_q[SYNC_STAGES-2:0], bus.a};
      b_sync_q <= {b_sync_q[SYNC_STAGES-2:0], bus.b};
    end
  end

  assign s = {a_sync_q[SYNC_STAGES-1], b_sync_q[SYNC_STAGES-1]};

  // Classify the previous->current phase pair
  always_comb begin
    ev_up  = 1'b0;
    ev_dn  = 1'b0;
    ev_bad = 1'b0;
    case ({prev_q, s})
      4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: ev_up  = 1'b1;
      4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: ev_dn  = 1'b1;
      4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: ev_bad = 1'b1;
      default: ;
    endcase
  end

  // Next state and next register values; clear overrides count and error
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prev_d  = prev_q;
    out_d   = out_q;
    dir_d   = dir_q;
    step_d  = 1'b0;
    err_d   = err_q;

    case (state_q)
      ST_INIT: begin
        // Wait until the synchronizer output holds a real post-reset sample
        if (cnt_q == CNT_W'(SYNC_STAGES)) begin
          prev_d  = s;
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RUN: begin
        prev_d = s;
        if (ev_up) begin
          step_d = 1'b1;
          dir_d  = 1'b0;
          if (out_q != OUT_MAX) out_d = out_q + WIDTH'(1);
        end else if (ev_dn) begin
          step_d = 1'b1;
          dir_d  = 1'b1;
          if (out_q != '0) out_d = out_q - WIDTH'(1);
        end else if (ev_bad) begin
          err_d = 1'b1;
        end
      end
      default: state_d = ST_INIT;
    endcase

    if (bus.clr) begin
      out_d = '0;
      err_d = 1'b0;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      prev_q  <= 2'b00;
      out_q   <= '0;
      dir_q   <= 1'b0;
      step_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prev_q  <= prev_d;
      out_q   <= out_d;
      dir_q   <= dir_d;
      step_q  <= step_d;
      err_q   <= err_d;
    end
  end

  assign bus.out  = out_q;
  assign bus.dir  = dir_q;
  assign bus.step = step_q;
  assign bus.err  = err_q;
  assign bus.sat  = (out_q == '0) || (out_q == OUT_MAX);

endmodule

// File: tb/tb_quadrature_decoder.sv
// Bench for quadrature_decoder: directed phase sequences, a position-based
// reference model checked every cycle, and literal checkpoints.
module tb_quadrature_decoder;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned S     = 2;
  localparam int          MAXV  = (1 << WIDTH) - 1;

  logic clk;
  logic rst_n;

  quadrature_decoder_if #(.WIDTH(WIDTH)) bus ();

  quadrature_decoder #(.WIDTH(WIDTH), .SYNC_STAGES(S)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;
  int step_cnt = 0;
  int pos = 0;

  // Reference model state
  int         m_out, m_dir, m_step, m_err, m_prev, edge_n, d;
  logic [1:0] hist[$];

  function automatic logic [1:0] gray(input int p);
    case (p & 3)
      0:       return 2'b00;
      1:       return 2'b01;
      2:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  function automatic int gpos(input logic [1:0] v);
    case (v)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  task automatic check(input string name, input int got, input int exp);
    nchk++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s at %0t: got=%0d expected=%0d", name, $time, got, exp);
    end
  endtask

  // Model: position delta (mod 4) of the input seen S edges ago
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_out = 0; m_dir = 0; m_step = 0; m_err = 0; m_prev = 0; edge_n = 0;
      hist.delete();
      hist.push_back(2'b00);
    end else begin
      edge_n++;
      hist.push_back({bus.a, bus.b});
      m_step = 0;
      if (edge_n == S + 1) begin
        m_prev = gpos(hist[1]);
      end else if (edge_n > S + 1) begin
        d = (gpos(hist[edge_n - S]) - m_prev + 4) % 4;
        if (d == 1) begin
          m_step = 1; m_dir = 0;
          if (m_out < MAXV) m_out++;
        end else if (d == 3) begin
          m_step = 1; m_dir = 1;
          if (m_out > 0) m_out--;
        end else if (d == 2) begin
          m_err = 1;
        end
        m_prev = gpos(hist[edge_n - S]);
      end
      if (bus.clr) begin
        m_out = 0;
        m_err = 0;
      end
    end
  end

  // Per-cycle compare against the model
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      check("cyc_out",  int'(bus.out),  m_out);
      check("cyc_dir",  int'(bus.dir),  m_dir);
      check("cyc_step", int'(bus.step), m_step);
      check("cyc_err",  int'(bus.err),  m_err);
      check("cyc_sat",  int'(bus.sat),  (m_out == 0 || m_out == MAXV) ? 1 : 0);
      if (bus.step) step_cnt++;
    end
  end

  task automatic drive_pos(input int p, input int hold);
    @(negedge clk);
    {bus.a, bus.b} = gray(p);
    repeat (hold - 1) @(negedge clk);
  endtask

  task automatic fwd(input int n);
    for (int i = 0; i < n; i++) begin
      pos = (pos + 1) % 4;
      drive_pos(pos, 4);
    end
  endtask

  task automatic rev(input int n);
    for (int i = 0; i < n; i++) begin
      pos = (pos + 3) % 4;
      drive_pos(pos, 4);
    end
  endtask

  task automatic settle();
    repeat (6) @(negedge clk);
  endtask

  int base;

  initial begin
    rst_n   = 1'b0;
    bus.clr = 1'b0;
    pos     = 2;
    {bus.a, bus.b} = gray(pos);
    repeat (3) @(negedge clk);
    check("rst_out",  int'(bus.out),  0);
    check("rst_dir",  int'(bus.dir),  0);
    check("rst_step", int'(bus.step), 0);
    check("rst_err",  int'(bus.err),  0);
    check("rst_sat",  int'(bus.sat),  1);

    // Release with both phases high: no spurious step
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("init_steps", step_cnt, 0);
    check("init_out",   int'(bus.out), 0);
    check("init_err",   int'(bus.err), 0);

    // Four full forward cycles, saturating at the top
    base = step_cnt;
    fwd(16);
    settle();
    check("fwd_steps", step_cnt - base, 16);
    check("fwd_out",   int'(bus.out), 15);
    check("fwd_dir",   int'(bus.dir), 0);
    check("fwd_sat",   int'(bus.sat), 1);

    // Five reverse steps from the top
    base = step_cnt;
    rev(5);
    settle();
    check("rev_steps", step_cnt - base, 5);
    check("rev_out",   int'(bus.out), 10);
    check("rev_dir",   int'(bus.dir), 1);
    check("rev_sat",   int'(bus.sat), 0);

    // Illegal jump: error set, count held
    base = step_cnt;
    pos = (pos + 2) % 4;
    drive_pos(pos, 4);
    settle();
    check("jump_err",   int'(bus.err), 1);
    check("jump_out",   int'(bus.out), 10);
    check("jump_steps", step_cnt - base, 0);

    fwd(2);
    settle();
    check("post_jump_out", int'(bus.out), 12);
    check("post_jump_err", int'(bus.err), 1);

    // Clear landing on the same edge as a forward step
    base = step_cnt;
    @(negedge clk);
    pos = (pos + 1) % 4;
    {bus.a, bus.b} = gray(pos);
    repeat (S) @(negedge clk);
    bus.clr = 1'b1;
    @(negedge clk);
    bus.clr = 1'b0;
    settle();
    check("clr_out",   int'(bus.out), 0);
    check("clr_err",   int'(bus.err), 0);
    check("clr_dir",   int'(bus.dir), 0);
    check("clr_steps", step_cnt - base, 1);

    // Reverse at zero stays at zero
    base = step_cnt;
    rev(3);
    settle();
    check("floor_out",   int'(bus.out), 0);
    check("floor_dir",   int'(bus.dir), 1);
    check("floor_steps", step_cnt - base, 3);
    check("floor_sat",   int'(bus.sat), 1);

    // Build out=7, dir=1, err=1 then reset asynchronously between edges
    pos = (pos + 2) % 4;
    drive_pos(pos, 4);
    fwd(8);
    rev(1);
    settle();
    check("pre_rst_out", int'(bus.out), 7);
    check("pre_rst_dir", int'(bus.dir), 1);
    check("pre_rst_err", int'(bus.err), 1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out",  int'(bus.out),  0);
    check("arst_dir",  int'(bus.dir),  0);
    check("arst_err",  int'(bus.err),  0);
    check("arst_step", int'(bus.step), 0);
    check("arst_sat",  int'(bus.sat),  1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    base = step_cnt;
    check("rerun_idle", step_cnt - base, 0);
    fwd(1);
    settle();
    check("rerun_out",   int'(bus.out), 1);
    check("rerun_steps", step_cnt - base, 1);
    check("rerun_err",   int'(bus.err), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/quadrature_decoder.md
Name: quadrature_decoder

Overview:
- Decodes a two-phase quadrature input pair (a, b) into up/down steps.
- Accumulates the steps in a saturating position counter.
- Sits at the input side of a counting path: it turns raw encoder phases into the same up/down semantics as the team's up/down counter (direction 0 = up, 1 = down).
- Flags illegal phase jumps.

Parameters:
- WIDTH, 4, width of position counter out.
- SYNC_STAGES, 2, flip-flop stages in each input synchronizer (legal range 2..4).

Ports:
- clk  input  1  rising-edge system clock.
- rst_n  input  1  asynchronous, active-low reset.
- a  input  1  quadrature phase A, asynchronous to clk.
- b  input  1  quadrature phase B, asynchronous to clk.
- clr  input  1  synchronous clear of out and err.
- out  output  WIDTH  saturating position count.
- dir  output  1  direction of last valid step (0 = up, 1 = down).
- step  output  1  one-cycle pulse per valid decoded transition.
- err  output  1  sticky illegal-transition flag.
- sat  output  1  high when out == 0 or out == 2^WIDTH-1.

Behaviour:
- Reset (rst_n low, asynchronous):
  - out = 0, dir = 0, step = 0, err = 0.
  - All synchronizer flops = 0, previous-phase register = 00, FSM = INIT.
  - sat = 1, since out == 0.
- Synchronizer: a and b each pass through SYNC_STAGES flops; the synchronized pair is s = {a_s, b_s}.
- FSM state INIT:
  - A counter runs for SYNC_STAGES cycles after reset release; no decoding takes place.
  - On the last INIT cycle, prev is loaded with s and the FSM moves to RUN.
  - This prevents a false step when the inputs are non-zero at reset release.
- FSM state RUN: each cycle, s is compared with prev, then prev <= s.
  - s == prev: no event, step = 0.
  - Forward sequence 00->01->11->10->00: up step, dir <= 0, step = 1.
  - Reverse sequence 00->10->11->01->00: down step, dir <= 1, step = 1.
  - Both bits changed (00<->11, 01<->10): err <= 1, step = 0, out and dir unchanged.
- Count rule:
  - Up step: out increments only if out < 2^WIDTH-1.
  - Down step: out decrements only if out > 0.
  - No wrap-around. step still pulses when saturated.
- Latency: a single-bit input change that completes before edge k appears on out/step/dir after edge k+SYNC_STAGES. That is 3 edges for the default.
- step is registered: high for exactly one clk cycle per valid transition.
- clr:
  - Synchronous: out <= 0, err <= 0.
  - Has priority over a same-cycle step; that step's count update is dropped.
  - dir and step still reflect the decoded event.
  - prev still updates.
- err stays set until clr or reset.
- sat is combinational from out.
- Reset asserted mid-operation: all state returns to reset values immediately and INIT repeats on release.
- Input timing: the inputs must hold each phase for at least 2 clk cycles; faster edges may alias and are reported as err.

Test Plan:
- Release reset with a = 1, b = 1 held -> after INIT, step never pulses; out = 0, err = 0.
- Four full forward cycles (16 transitions, each phase held 4 clks) -> 16 step pulses, dir = 0, out counts 0..15 then holds 15, sat = 1 from the 15th step onward.
- From out = 15, apply 5 reverse transitions -> out = 10, dir = 1, 5 step pulses, sat = 0.
- Apply 00->11 jump -> err = 1, out unchanged, step = 0; continue forward 2 steps -> out increments by 2, err stays 1; pulse clr -> out = 0, err = 0.
- With out = 0, apply 3 reverse transitions -> out stays 0, dir = 1, 3 step pulses, sat = 1.
- Assert rst_n low mid-sequence with out = 7 -> out = 0, dir = 0, err = 0 asynchronously, without waiting for a clk edge; first valid transition after INIT counts out = 1.
